// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer: start bit, DATA_W data bits, optional parity, STOP_BITS stop bits.
// One bit period per baud_tick_i; tx_o is a registered line that idles high.
module uart_tx_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              baud_tick_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] load_word;
  logic [CW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic              par;
  logic              accept;
  logic              last_data;
  logic              last_stop;

  assign accept    = valid_i & ready_o;
  assign last_data = (bit_cnt == CW'(DATA_W - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  // Pulses during the tick that ends the last stop period, so ready_o rises the cycle after.
  assign done_o  = (state == STOP) & baud_tick_i & last_stop;

  // Word as loaded into the shift register: reversed for MSB-first so we always shift out bit 0.
  always_comb begin
    load_word = data_i;
    if (LSB_FIRST == 0) begin
      for (int i = 0; i < DATA_W; i++) load_word[i] = data_i[DATA_W-1-i];
    end
  end

  // Frame sequencer: state, shift register, counters and the registered serial line.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      tx_o     <= 1'b1;
      sreg     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (accept) begin
            sreg  <= load_word;
            par   <= (^data_i) ^ 1'(PARITY_ODD);
            state <= LOAD;
          end
        end
        LOAD: begin
          if (baud_tick_i) begin
            tx_o  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tick_i) begin
            tx_o    <= sreg[0];
            sreg    <= sreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick_i) begin
            if (last_data) begin
              if (PARITY_EN != 0) begin
                tx_o  <= par;
                state <= PARITY;
              end else begin
                tx_o     <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              tx_o    <= sreg[0];
              sreg    <= sreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_tick_i) begin
            tx_o     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (baud_tick_i) begin
            if (last_stop) begin
              state <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Randomized bench for uart_tx_frame_serializer: five parameter variants share clk, nrst and
// the baud tick; each frame is compared bit-by-bit against a list built from the framing rules.
module tb_uart_tx_frame_serializer;

  localparam int N = 5;
  localparam int DW [N] = '{8, 8, 8, 8, 9};
  localparam int PE [N] = '{0, 0, 1, 1, 1};
  localparam int PO [N] = '{0, 0, 0, 1, 0};
  localparam int SB [N] = '{1, 1, 2, 1, 2};
  localparam int LF [N] = '{1, 0, 1, 1, 0};

  logic                clk = 1'b0;
  logic                nrst;
  logic                baud;
  logic [N-1:0][8:0]   data;
  logic [N-1:0]        valid;
  logic [N-1:0]        ready, tx, busy, done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame_serializer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .LSB_FIRST(1)) u0 (
    .clk(clk), .nrst(nrst), .data_i(data[0][7:0]), .valid_i(valid[0]), .ready_o(ready[0]),
    .baud_tick_i(baud), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
  uart_tx_frame_serializer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .LSB_FIRST(0)) u1 (
    .clk(clk), .nrst(nrst), .data_i(data[1][7:0]), .valid_i(valid[1]), .ready_o(ready[1]),
    .baud_tick_i(baud), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
  uart_tx_frame_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .LSB_FIRST(1)) u2 (
    .clk(clk), .nrst(nrst), .data_i(data[2][7:0]), .valid_i(valid[2]), .ready_o(ready[2]),
    .baud_tick_i(baud), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
  uart_tx_frame_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .LSB_FIRST(1)) u3 (
    .clk(clk), .nrst(nrst), .data_i(data[3][7:0]), .valid_i(valid[3]), .ready_o(ready[3]),
    .baud_tick_i(baud), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));
  uart_tx_frame_serializer #(.DATA_W(9), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .LSB_FIRST(0)) u4 (
    .clk(clk), .nrst(nrst), .data_i(data[4][8:0]), .valid_i(valid[4]), .ready_o(ready[4]),
    .baud_tick_i(baud), .tx_o(tx[4]), .busy_o(busy[4]), .done_o(done[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected line levels for each bit period of a frame, straight from the framing rules.
  task automatic build(input int k, input int w);
    int ones;
    exp_q = {};
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW[k]; i++) begin
      int idx;
      idx = (LF[k] != 0) ? i : DW[k] - 1 - i;
      exp_q.push_back(bit'((w >> idx) & 1));
      ones += (w >> i) & 1;
    end
    if (PE[k] != 0) exp_q.push_back(bit'((ones % 2) ^ PO[k]));
    for (int i = 0; i < SB[k]; i++) exp_q.push_back(1'b1);
  endtask

  // Send one word on instance k; called at a negedge with the instance idle.
  task automatic send(input int k, input int w, input int gap, input bit tick_acc,
                      input bit hold, input int nxt, input int load_wait);
    int len;
    build(k, w);
    len = exp_q.size();
    data[k]  = 9'(w);
    valid[k] = 1'b1;
    baud     = tick_acc;
    #1;
    chk($sformatf("i%0d idle_ready", k), ready[k], 1);
    chk($sformatf("i%0d idle_tx", k), tx[k], 1);
    @(negedge clk);
    baud = 1'b0;
    if (hold) data[k] = 9'(nxt);
    else begin
      valid[k] = 1'b0;
      data[k]  = 9'($urandom);
    end
    chk($sformatf("i%0d load_busy", k), busy[k], 1);
    chk($sformatf("i%0d load_ready", k), ready[k], 0);
    chk($sformatf("i%0d load_tx", k), tx[k], 1);
    repeat (load_wait) @(negedge clk);
    if (load_wait > 0) chk($sformatf("i%0d load_hold_tx", k), tx[k], 1);
    for (int t = 0; t <= len; t++) begin
      repeat (gap - 1) @(negedge clk);
      baud = 1'b1;
      #1;
      chk($sformatf("i%0d done_t%0d", k, t), done[k], (t == len) ? 1 : 0);
      if (t < len) chk($sformatf("i%0d ready_t%0d", k, t), ready[k], 0);
      @(negedge clk);
      baud = 1'b0;
      if (t < len) chk($sformatf("i%0d bit%0d", k, t), tx[k], exp_q[t]);
      else begin
        chk($sformatf("i%0d end_ready", k), ready[k], 1);
        chk($sformatf("i%0d end_busy", k), busy[k], 0);
        chk($sformatf("i%0d end_done", k), done[k], 0);
        chk($sformatf("i%0d end_tx", k), tx[k], 1);
      end
    end
  endtask

  initial begin
    nrst  = 1'b0;
    baud  = 1'b0;
    valid = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("i%0d rst_tx", k), tx[k], 1);
      chk($sformatf("i%0d rst_ready", k), ready[k], 1);
      chk($sformatf("i%0d rst_busy", k), busy[k], 0);
      chk($sformatf("i%0d rst_done", k), done[k], 0);
    end
    nrst = 1'b1;
    @(negedge clk);

    // 0x1D on every variant; default variant at a 16-clock bit period.
    send(0, 'h1D, 16, 0, 0, 0, 0);
    for (int k = 1; k < N; k++) send(k, 'h1D, 2, 0, 0, 0, 1);

    // Back-to-back words with valid held through the first frame.
    send(0, 'h55, 3, 0, 1, 'hAA, 0);
    send(0, 'hAA, 3, 0, 0, 0, 0);

    // Tick in the accept cycle, then a LOAD stretch with no ticks.
    send(0, int'($urandom), 2, 1, 0, 0, 5);
    send(2, int'($urandom), 1, 1, 0, 0, 3);

    // Abort mid-DATA with reset; all-zero word keeps the line low before reset.
    build(0, 0);
    data[0] = '0; valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
    chk("abort_pre_tx", tx[0], exp_q[3]);
    chk("abort_pre_busy", busy[0], 1);
    nrst = 1'b0;
    #1;
    chk("abort_tx", tx[0], 1);
    chk("abort_ready", ready[0], 1);
    chk("abort_busy", busy[0], 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    send(0, 'hC3, 2, 0, 0, 0, 0);

    // Random traffic over all variants, in back-to-back pairs.
    for (int n = 0; n < 12; n++) begin
      int k, w1, w2, g;
      k  = int'($urandom_range(0, N - 1));
      w1 = int'($urandom_range(0, 511));
      w2 = int'($urandom_range(0, 511));
      g  = int'($urandom_range(1, 4));
      send(k, w1, g, bit'($urandom_range(0, 1)), 1, w2, int'($urandom_range(0, 2)));
      send(k, w2, g, 0, 0, 0, int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
